// File: rtl/dram_ctrl_pkg.sv
// Shared types and constants for the asynchronous DRAM controller.
package dram_ctrl_pkg;

  localparam int unsigned ADDR_W  = 20;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned MA_W    = 10;
  localparam int unsigned BE_W    = 2;
  localparam int unsigned ROW_LSB = 0;
  localparam int unsigned ROW_MSB = 9;
  localparam int unsigned COL_LSB = 10;
  localparam int unsigned COL_MSB = 19;

  typedef enum logic [2:0] {
    IDLE,
    RAS,
    CAS,
    CAS_HOLD,
    PRE,
    REF_CAS,
    REF_RAS,
    REF_HOLD
  } state_t;

  // One word request as latched from the arbiter.
  typedef struct packed {
    logic              rnw;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } dram_req_t;

  function automatic logic [MA_W-1:0] row_of(input logic [ADDR_W-1:0] a);
    return a[ROW_MSB:ROW_LSB];
  endfunction

  function automatic logic [MA_W-1:0] col_of(input logic [ADDR_W-1:0] a);
    return a[COL_MSB:COL_LSB];
  endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval counter with a sticky refresh request flag.
module dram_refresh_timer #(
  parameter int unsigned PERIOD = 512
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic ref_pending
);

  localparam int unsigned CW = $clog2(PERIOD);
  localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  // Count down; expiry sets the request and wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= RELOAD;
      ref_pending <= 1'b0;
    end else if (cnt == '0) begin
      cnt         <= RELOAD;
      ref_pending <= 1'b1;
    end else begin
      cnt <= cnt - CW'(1);
      if (clr) begin
        ref_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dram_ctrl.sv
// Single-port word controller for a 16-bit asynchronous DRAM with CBR refresh.
module dram_ctrl
  import dram_ctrl_pkg::*;
#(
  parameter int unsigned REFRESH_PERIOD = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              rnw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BE_W-1:0]   be,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [MA_W-1:0]   ma,
  inout  wire  [DATA_W-1:0] d,
  output logic              ras_n,
  output logic              ucas_n,
  output logic              lcas_n,
  output logic              we_n
);

  state_t    state;
  state_t    state_nx;
  dram_req_t cur;
  dram_req_t in_c;
  dram_req_t eff_c;

  logic            ref_pending;
  logic            ref_clr_c;
  logic            accept_c;
  logic            rd_done_c;
  logic            d_oe;
  logic            d_oe_nx;
  logic            ras_n_nx;
  logic            ucas_n_nx;
  logic            lcas_n_nx;
  logic            we_n_nx;
  logic [MA_W-1:0] ma_nx;

  dram_refresh_timer #(
    .PERIOD (REFRESH_PERIOD)
  ) u_refresh_timer (
    .clk         (clk),
    .rst         (rst),
    .clr         (ref_clr_c),
    .ref_pending (ref_pending)
  );

  assign ready = (state == IDLE) && !ref_pending;

  // Write data comes straight from the latched request while the bus is owned.
  assign d = d_oe ? cur.wdata : {DATA_W{1'bz}};

  // Next state and next pin values, decoded from the state being entered.
  always_comb begin
    in_c.rnw   = rnw;
    in_c.addr  = addr;
    in_c.be    = be;
    in_c.wdata = wdata;
    accept_c   = (state == IDLE) && !ref_pending && req;
    eff_c      = accept_c ? in_c : cur;
    ref_clr_c  = (state == REF_HOLD);
    rd_done_c  = (state == CAS_HOLD) && cur.rnw;
    state_nx   = state;
    ras_n_nx   = 1'b1;
    ucas_n_nx  = 1'b1;
    lcas_n_nx  = 1'b1;
    we_n_nx    = 1'b1;
    d_oe_nx    = 1'b0;
    ma_nx      = ma;

    case (state)
      IDLE: begin
        if (ref_pending) begin
          state_nx = REF_CAS;
        end else if (req) begin
          state_nx = RAS;
        end
      end
      RAS:      state_nx = CAS;
      CAS:      state_nx = CAS_HOLD;
      CAS_HOLD: state_nx = PRE;
      PRE:      state_nx = IDLE;
      REF_CAS:  state_nx = REF_RAS;
      REF_RAS:  state_nx = REF_HOLD;
      REF_HOLD: state_nx = PRE;
      default:  state_nx = IDLE;
    endcase

    case (state_nx)
      RAS: begin
        ras_n_nx = 1'b0;
        ma_nx    = row_of(eff_c.addr);
        if (!eff_c.rnw) begin
          we_n_nx = 1'b0;
          d_oe_nx = 1'b1;
        end
      end
      CAS, CAS_HOLD: begin
        ras_n_nx = 1'b0;
        ma_nx    = col_of(eff_c.addr);
        if (eff_c.rnw) begin
          ucas_n_nx = 1'b0;
          lcas_n_nx = 1'b0;
        end else begin
          ucas_n_nx = ~eff_c.be[1];
          lcas_n_nx = ~eff_c.be[0];
          we_n_nx   = 1'b0;
          d_oe_nx   = 1'b1;
        end
      end
      REF_CAS: begin
        ucas_n_nx = 1'b0;
        lcas_n_nx = 1'b0;
      end
      REF_RAS, REF_HOLD: begin
        ras_n_nx  = 1'b0;
        ucas_n_nx = 1'b0;
        lcas_n_nx = 1'b0;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Request latch, loaded on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= '0;
    end else if (accept_c) begin
      cur <= in_c;
    end
  end

  // DRAM pin registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_n  <= 1'b1;
      ucas_n <= 1'b1;
      lcas_n <= 1'b1;
      we_n   <= 1'b1;
      d_oe   <= 1'b0;
      ma     <= '0;
    end else begin
      ras_n  <= ras_n_nx;
      ucas_n <= ucas_n_nx;
      lcas_n <= lcas_n_nx;
      we_n   <= we_n_nx;
      d_oe   <= d_oe_nx;
      ma     <= ma_nx;
    end
  end

  // Read capture as CAS rises; rdata holds until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_done_c;
      if (rd_done_c) begin
        rdata <= d;
      end
    end
  end

endmodule

// File: tb/tb_dram_ctrl.sv
// Bench for dram_ctrl: DRAM pin model, read scoreboard, vector table and corner sequences.
`timescale 1ns/1ps
module tb_dram_ctrl;

  localparam int unsigned PERIOD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        rnw;
  logic [19:0] addr;
  logic [1:0]  be;
  logic [15:0] wdata;
  logic        ready;
  logic [15:0] rdata;
  logic        rvalid;
  logic [9:0]  ma;
  wire  [15:0] d;
  logic        ras_n, ucas_n, lcas_n, we_n;

  logic        mdl_drv = 1'b0;
  logic [15:0] mdl_val = 16'h0;
  logic        tb_drv  = 1'b0;

  assign d = mdl_drv ? mdl_val : (tb_drv ? 16'h0000 : 16'hzzzz);

  dram_ctrl #(.REFRESH_PERIOD(PERIOD)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .rnw    (rnw),
    .addr   (addr),
    .be     (be),
    .wdata  (wdata),
    .ready  (ready),
    .rdata  (rdata),
    .rvalid (rvalid),
    .ma     (ma),
    .d      (d),
    .ras_n  (ras_n),
    .ucas_n (ucas_n),
    .lcas_n (lcas_n),
    .we_n   (we_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // DRAM model: row latched on RAS fall, column on CAS, CBR detected when CAS leads RAS.
  logic [15:0] mem [0:1048575];
  logic [9:0]  row_q;
  logic        ras_q = 1'b1, ucas_q = 1'b1, lcas_q = 1'b1, we_q = 1'b1;
  logic        in_cbr = 1'b0;
  int          cas_fall_cyc = 0;
  int          cbr_cnt = 0;
  int          cbr_cyc = 0;

  always @(negedge clk) begin
    logic cas_lo;
    cas_lo = !ucas_n || !lcas_n;
    if (cas_lo && ucas_q && lcas_q) begin
      cas_fall_cyc = cyc;
      check("cas_ras_same_edge", {31'd0, ras_q & ~ras_n}, 0);
      if (!ras_n && !we_n) check("we_setup_before_cas", {31'd0, we_q}, 0);
    end
    if (!ras_n && ras_q) begin
      if (cas_lo) begin
        cbr_cnt++;
        cbr_cyc = cas_fall_cyc;
        in_cbr  = 1'b1;
        check("cbr_cas_lead", cyc - cas_fall_cyc, 1);
        check("cbr_we_n", {31'd0, we_n}, 1);
      end else begin
        row_q = ma;
      end
    end
    if (ras_n) in_cbr = 1'b0;
    if (!ras_n && !in_cbr && cas_lo && !we_n) begin
      if (!ucas_n) mem[{ma, row_q}][15:8] = d[15:8];
      if (!lcas_n) mem[{ma, row_q}][7:0]  = d[7:0];
    end
    if (!ras_n && !in_cbr && cas_lo && we_n) begin
      mdl_drv = 1'b1;
      mdl_val = mem[{ma, row_q}];
    end else begin
      mdl_drv = 1'b0;
    end
    ras_q  = ras_n;
    ucas_q = ucas_n;
    lcas_q = lcas_n;
    we_q   = we_n;
  end

  // Read scoreboard: expected data and due cycle pushed at accept, popped on rvalid.
  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rvalid) begin
      if (sb.size() == 0) begin
        check("rvalid_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check("rdata", {16'd0, rdata}, {16'd0, e.data});
        check("rvalid_latency", cyc, e.due);
      end
    end
  end

  task automatic do_req(input logic r, input logic [19:0] a, input logic [1:0] b,
                        input logic [15:0] w, input logic [15:0] exp_d, output int acc);
    exp_t e;
    int   budget;
    budget = 0;
    @(negedge clk);
    req = 1'b1; rnw = r; addr = a; be = b; wdata = w;
    while (!ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!ready) begin
      check("accept_timeout", 0, 1);
      req = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (r) begin
      e.data = exp_d;
      e.due  = acc + 3;
      sb.push_back(e);
    end
  endtask

  task automatic release_req();
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while (sb.size() != 0 && b < 60) begin
      @(negedge clk);
      b++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic wait_cbr(output int c);
    int n, b;
    n = cbr_cnt;
    b = 0;
    while (cbr_cnt == n && b < 40) begin
      @(negedge clk);
      b++;
    end
    if (cbr_cnt == n) check("cbr_timeout", 0, 1);
    c = cbr_cyc;
  endtask

  typedef struct packed {
    logic        rnw;
    logic [19:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic [15:0] exp_d;
  } vec_t;
  vec_t tbl [9];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, prev_acc, prev_cbr, c1, c2, c3;

    tbl[0] = '{1'b1, 20'h12345, 2'b00, 16'h0000, 16'hBEEF};
    tbl[1] = '{1'b0, 20'h00100, 2'b11, 16'hAAAA, 16'h0000};
    tbl[2] = '{1'b0, 20'h00100, 2'b01, 16'h1234, 16'h0000};
    tbl[3] = '{1'b1, 20'h00100, 2'b00, 16'h0000, 16'hAA34};
    tbl[4] = '{1'b0, 20'h00100, 2'b10, 16'h5600, 16'h0000};
    tbl[5] = '{1'b1, 20'h00100, 2'b00, 16'h0000, 16'h5634};
    tbl[6] = '{1'b0, 20'h00100, 2'b00, 16'hFFFF, 16'h0000};
    tbl[7] = '{1'b1, 20'h00100, 2'b00, 16'h0000, 16'h5634};
    tbl[8] = '{1'b1, 20'h12345, 2'b00, 16'h0000, 16'hBEEF};

    rst = 1'b1; req = 1'b0; rnw = 1'b0; addr = '0; be = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ras_n", {31'd0, ras_n}, 1);
    check("rst_ucas_n", {31'd0, ucas_n}, 1);
    check("rst_lcas_n", {31'd0, lcas_n}, 1);
    check("rst_we_n", {31'd0, we_n}, 1);
    check("rst_ma", {22'd0, ma}, 0);
    check("rst_rdata", {16'd0, rdata}, 0);
    check("rst_rvalid", {31'd0, rvalid}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, ready}, 1);

    // First write with pin-level checks through each phase.
    do_req(1'b0, 20'h12345, 2'b11, 16'hBEEF, 16'h0, acc);
    release_req();
    check("ras_ph_ma", {22'd0, ma}, 32'h345);
    check("ras_ph_strobes", {28'd0, ras_n, ucas_n, lcas_n, we_n}, 4'b0110);
    check("ras_ph_d", {16'd0, d}, 32'hBEEF);
    @(negedge clk);
    check("cas_ph_ma", {22'd0, ma}, 32'h048);
    check("cas_ph_strobes", {28'd0, ras_n, ucas_n, lcas_n, we_n}, 4'b0000);
    check("cas_ph_d", {16'd0, d}, 32'hBEEF);
    @(negedge clk);
    check("hold_ph_strobes", {28'd0, ras_n, ucas_n, lcas_n, we_n}, 4'b0000);
    @(negedge clk);
    check("pre_ph_strobes", {28'd0, ras_n, ucas_n, lcas_n, we_n}, 4'b1111);
    check("pre_ph_ma", {22'd0, ma}, 32'h048);

    // Vector table: byte-enable merges and read-back.
    for (int i = 0; i < 9; i++) begin
      do_req(tbl[i].rnw, tbl[i].addr, tbl[i].be, tbl[i].wdata, tbl[i].exp_d, acc);
      release_req();
      if (tbl[i].rnw) wait_drain();
    end
    repeat (3) @(negedge clk);
    check("rdata_held", {16'd0, rdata}, 32'hBEEF);

    // Idle refresh cadence.
    wait_cbr(c1);
    wait_cbr(c2);
    check("cbr_interval_1", c2 - c1, PERIOD);
    wait_cbr(c3);
    check("cbr_interval_2", c3 - c2, PERIOD);

    // Accept a request on the edge the timer expires.
    while (cyc < c3 + 14) @(negedge clk);
    check("coinc_ready", {31'd0, ready}, 1);
    req = 1'b1; rnw = 1'b0; addr = 20'h00200; be = 2'b11; wdata = 16'h1357;
    @(posedge clk);
    #1;
    acc = cyc;
    check("coinc_accept_cyc", acc, c3 + 15);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req = 1'b0;
      check("coinc_ready_seq", {31'd0, ready}, (k == 9) ? 1 : 0);
    end
    check("coinc_cbr_cyc", cbr_cyc, acc + 5);
    do_req(1'b1, 20'h00200, 2'b00, 16'h0, 16'h1357, acc);
    release_req();
    wait_drain();
    do_req(1'b1, 20'h12345, 2'b00, 16'h0, 16'hBEEF, acc);
    release_req();
    wait_drain();

    // Reset asserted during the CAS phase of a write.
    do_req(1'b0, 20'h00300, 2'b11, 16'h2468, 16'h0, acc);
    release_req();
    @(negedge clk);
    #2;
    rst = 1'b1;
    tb_drv = 1'b1;
    #1;
    check("mid_rst_strobes", {28'd0, ras_n, ucas_n, lcas_n, we_n}, 4'b1111);
    check("mid_rst_d_released", {16'd0, d}, 0);
    check("mid_rst_ma", {22'd0, ma}, 0);
    @(negedge clk);
    rst = 1'b0;
    tb_drv = 1'b0;
    sb.delete();
    do_req(1'b0, 20'h00301, 2'b11, 16'h9ABC, 16'h0, acc);
    release_req();
    do_req(1'b1, 20'h00301, 2'b00, 16'h0, 16'h9ABC, acc);
    release_req();
    wait_drain();

    // Back-to-back held requests: writes then reads.
    prev_acc = -1;
    prev_cbr = cbr_cnt;
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, 20'h01000 + 20'(i), 2'b11, 16'hC000 + 16'(i * 16'h0111), 16'h0, acc);
      if (prev_acc >= 0) check("b2b_wr_spacing", acc - prev_acc, 5 + 5 * (cbr_cnt - prev_cbr));
      prev_acc = acc;
      prev_cbr = cbr_cnt;
    end
    prev_acc = -1;
    for (int i = 0; i < 8; i++) begin
      do_req(1'b1, 20'h01000 + 20'(i), 2'b00, 16'h0, 16'hC000 + 16'(i * 16'h0111), acc);
      if (prev_acc >= 0) check("b2b_rd_spacing", acc - prev_acc, 5 + 5 * (cbr_cnt - prev_cbr));
      prev_acc = acc;
      prev_cbr = cbr_cnt;
    end
    release_req();
    wait_drain();
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
